uart_rx: RTL
============

# uart_rx

Oversampling UART receiver that turns the host serial line into bytes for the command path. Sits directly upstream of the packet decoder inside `diff_freq_serial_out`: `data_o`/`rx_done_tick_o` drive its `data_i`/`rx_done_tick_i`. Frames are 8N1, or 8E1 when parity is compiled in. Only error-free bytes produce a done tick; bad frames raise error pulses instead.

## Interface
- `DATA_BIT`, 8, payload bits per frame, sent LSB first.
- `CLK_DIV`, 27, system clocks per oversample tick. 50 MHz / (115200 × 16) ≈ 27. Must be ≥ 2.
- `SB_TICK`, 16, oversample ticks in the stop bit. Use 16 for 1 stop bit, 24 for 1.5, 32 for 2.

- `clk_i`  in  1  system clock; all logic on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `rx_i`  in  1  serial line; idles high; asynchronous to `clk_i`.
- `data_o`  out  DATA_BIT  last good byte; holds until the next good byte.
- `rx_done_tick_o`  out  1  one-clock pulse; `data_o` is valid in the same cycle.
- `frame_err_o`  out  1  one-clock pulse when the stop bit is sampled low.
- `parity_err_o`  out  1  one-clock pulse on parity mismatch; tied 0 without the macro.

## Operation
- Input synchronizer:
  - 2-flop chain on `rx_i`, both flops reset to 1.
  - All FSM decisions use the second flop, `rx_s`.
- Tick generator:
  - Free-running counter `0..CLK_DIV-1`, width `$clog2(CLK_DIV)`.
  - `s_tick` is high for one clock when the count equals `CLK_DIV-1`.
- Counters:
  - `s_cnt` (4+ bits) counts `s_tick`s within a bit.
  - `n_cnt` (`$clog2(DATA_BIT)` bits) counts data bits.
- State machine: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE:
  - `rx_s == 0` → START, `s_cnt = 0`. Does not wait for `s_tick`.
- START (mid-bit check):
  - On `s_tick` with `s_cnt == 7`: if `rx_s == 0` → DATA, `s_cnt = 0`, `n_cnt = 0`.
  - If `rx_s == 1` at that point: false start, return to IDLE with no output activity.
- DATA:
  - On `s_tick` with `s_cnt == 15`: `shift = {rx_s, shift[DATA_BIT-1:1]}`, `s_cnt = 0`.
  - When `n_cnt == DATA_BIT-1` → PARITY if the macro is defined, otherwise STOP.
  - Otherwise `n_cnt++`.
- PARITY:
  - On `s_tick` with `s_cnt == 15`: latch `par_bad = rx_s ^ (^shift)` (even parity), then → STOP.
- STOP: on `s_tick` with `s_cnt == SB_TICK-1`, → IDLE and exactly one of:
  - `rx_s == 0`: pulse `frame_err_o`. `data_o` is unchanged, no done tick.
  - `par_bad`: pulse `parity_err_o`. `data_o` is unchanged, no done tick.
  - Good frame: `data_o <= shift`, pulse `rx_done_tick_o`.
  - Frame error takes priority if both errors occur.
- Counter boundaries:
  - `s_cnt` increments on every `s_tick` outside IDLE.
  - It wraps only through the explicit clears above and never exceeds `SB_TICK-1`.
- A falling edge on `rx_i` during STOP is ignored. The next start is detected only after the return to IDLE.

## Timing
- Reset values:
  - State IDLE; all counters 0.
  - `data_o = 0`, all three pulse outputs 0, synchronizer flops 1.
- Reset mid-frame aborts immediately: state returns to IDLE, the partial byte is discarded, no pulse is emitted.
- Start detection: 2 clocks of synchronizer latency after the falling edge of `rx_i`.
- Done tick latency from the start-bit falling edge:
  - (8 + 16·DATA_BIT + SB_TICK) oversample ticks, ±1 tick of phase jitter, plus 2–3 clocks.
  - Add 16 ticks for parity.
- Each output pulse is exactly 1 clock wide. Consecutive pulses are separated by at least one full frame.
- There is no backpressure. The consumer must accept `rx_done_tick_o` in the cycle it is high.
- Back-to-back frames: a start bit immediately after the stop bit is received correctly; zero idle bits are required between frames.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state and the `par_bad` logic are compiled in.
  - Frames are 8E1, and `parity_err_o` is live.
- Not defined:
  - No PARITY state; DATA goes straight to STOP.
  - `parity_err_o` is driven constant 0.
  - Frames are 8N1.

## Test plan
All scenarios use `CLK_DIV = 4` and `SB_TICK = 16`.
- Send byte 0x0B (8N1) → one `rx_done_tick_o` pulse with `data_o == 8'h0B` in that cycle; both error outputs stay 0.
- Send 0x0A then 0x55 back-to-back with no idle bits → two done ticks, 160 ticks ±1 apart, carrying 0x0A then 0x55.
- Drive a 4-tick low glitch on an idle line → no pulses, FSM back in IDLE, `data_o` unchanged.
- Send 0xA5 with the stop bit held low → `frame_err_o` pulses once, no done tick, `data_o` keeps its previous value.
- With the macro defined, send 0x03 with parity bit 1 → `parity_err_o` pulses once, no done tick. Resend with parity bit 0 → done tick with `data_o == 8'h03`.
- Assert `rst_ni` low during bit 4 of 0xFF, release, then send 0x3C → no pulse for the aborted frame; a single done tick with `data_o == 8'h3C`.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling 8N1/8E1 receiver; done tick about (8+16*DATA_BIT+SB_TICK) oversample ticks after start edge.
// No backpressure: pulses are single-cycle and must be consumed when high. Parity build: `define UART_RX_PARITY_EN.
module uart_rx #(
  parameter int DATA_BIT = 8,
  parameter int CLK_DIV  = 27,
  parameter int SB_TICK  = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rx_i,
  output logic [DATA_BIT-1:0] data_o,
  output logic                rx_done_tick_o,
  output logic                frame_err_o,
  output logic                parity_err_o
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [SW-1:0] MID_BIT   = SW'(7);
  localparam logic [SW-1:0] BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DATA_BIT - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic                rx_meta_q, rx_meta_d;
  logic                rx_s_q, rx_s_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [2:0]          state_q, state_d;
  logic [SW-1:0]       s_cnt_q, s_cnt_d;
  logic [NW-1:0]       n_cnt_q, n_cnt_d;
  logic [DATA_BIT-1:0] shift_q, shift_d;
  logic [DATA_BIT-1:0] data_q, data_d;
  logic                done_q, done_d;
  logic                ferr_q, ferr_d;
  logic                s_tick;
`ifdef UART_RX_PARITY_EN
  logic                par_bad_q, par_bad_d;
  logic                perr_q, perr_d;
`endif

  assign s_tick = (tick_q == TICK_LAST);

  always_comb begin
    rx_meta_d = rx_i;
    rx_s_d    = rx_meta_q;
    tick_d    = s_tick ? '0 : tick_q + 1'b1;
    state_d   = state_q;
    s_cnt_d   = s_cnt_q;
    n_cnt_d   = n_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        // Start detection is immediate; the tick phase only matters from START onward.
        if (!rx_s_q) begin
          state_d = ST_START;
          s_cnt_d = '0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_cnt_q == MID_BIT) begin
            s_cnt_d = '0;
            if (!rx_s_q) begin
              state_d = ST_DATA;
              n_cnt_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d = '0;
            shift_d = DATA_BIT'({rx_s_q, shift_q} >> 1);
            if (n_cnt_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              n_cnt_d = n_cnt_q + 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d   = '0;
            par_bad_d = rx_s_q ^ (^shift_q);
            state_d   = ST_STOP;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (s_tick) begin
          if (s_cnt_q == STOP_LAST) begin
            s_cnt_d = '0;
            state_d = ST_IDLE;
            // Framing error outranks parity error.
            if (!rx_s_q) begin
              ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad_q) begin
              perr_d = 1'b1;
`endif
            end else begin
              data_d = shift_q;
              done_d = 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        s_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      tick_q    <= '0;
      state_q   <= ST_IDLE;
      s_cnt_q   <= '0;
      n_cnt_q   <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      tick_q    <= tick_d;
      state_q   <= state_d;
      s_cnt_q   <= s_cnt_d;
      n_cnt_q   <= n_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
    end
  end

  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

  assign data_o         = data_q;
  assign rx_done_tick_o = done_q;
  assign frame_err_o    = ferr_q;

endmodule
